// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the shared data-memory port: m0 (CPU LSU) has priority,
// m1 (debug/loader) is promoted after MAX_WAIT denials; read data is routed back by owner tag.
module dmem_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [3:0]        starve_cnt
);

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_M0,
      OWN_M1
   } owner_e;

   localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

   owner_e            owner_q, owner_d;
   logic [ADDR_W-1:0] lastAddr_q, lastAddr_d;
   logic [3:0]        starve_q, starve_d;

   // Response owner, last granted address and m1 denial counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_q    <= OWN_NONE;
         lastAddr_q <= '0;
         starve_q   <= '0;
      end else begin
         owner_q    <= owner_d;
         lastAddr_q <= lastAddr_d;
         starve_q   <= starve_d;
      end
   end

   // Grants are suppressed during reset; with no winner the address is held so the fetch stays stable.
   always_comb begin
      m0_gnt     = 1'b0;
      m1_gnt     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = lastAddr_q;
      mem_wdata  = '0;
      owner_d    = OWN_NONE;
      lastAddr_d = lastAddr_q;
      starve_d   = starve_q;

      if (rst_n) begin
         if (m1_req && (!m0_req || (starve_q >= MaxWait))) begin
            m1_gnt = 1'b1;
         end else if (m0_req) begin
            m0_gnt = 1'b1;
         end
      end

      if (m0_gnt) begin
         mem_we     = m0_we;
         mem_addr   = m0_addr;
         mem_wdata  = m0_wdata;
         lastAddr_d = m0_addr;
         owner_d    = m0_we ? OWN_NONE : OWN_M0;
      end else if (m1_gnt) begin
         mem_we     = m1_we;
         mem_addr   = m1_addr;
         mem_wdata  = m1_wdata;
         lastAddr_d = m1_addr;
         owner_d    = m1_we ? OWN_NONE : OWN_M1;
      end

      if (!m1_req || m1_gnt) begin
         starve_d = '0;
      end else if (starve_q != 4'hF) begin
         starve_d = starve_q + 4'd1;
      end
   end

   assign m0_rvalid  = (owner_q == OWN_M0);
   assign m1_rvalid  = (owner_q == OWN_M1);
   assign m0_rdata   = m0_rvalid ? mem_rdata : '0;
   assign m1_rdata   = m1_rvalid ? mem_rdata : '0;
   assign starve_cnt = starve_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table of grants/starvation, a behavioural BRAM,
// and a queue of expected read responses checked one cycle after each read grant.
module tb_dmem_arbiter;

   logic        clk;
   logic        rst_n;
   logic        m0_req, m0_we, m0_gnt, m0_rvalid;
   logic [31:0] m0_addr, m0_wdata, m0_rdata;
   logic        m1_req, m1_we, m1_gnt, m1_rvalid;
   logic [31:0] m1_addr, m1_wdata, m1_rdata;
   logic        mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  starve_cnt;

   typedef struct {
      logic        r0, w0;
      logic [31:0] a0, d0;
      logic        r1, w1;
      logic [31:0] a1, d1;
      logic        eg0, eg1;
      logic [3:0]  eStarve;
   } vec_t;

   typedef struct {
      logic        who;
      logic [31:0] data;
   } rsp_t;

   vec_t        vecs[$];
   rsp_t        sb[$];
   logic [31:0] bram[64];
   logic [31:0] refMem[64];
   logic [31:0] lastAddr;
   int          total = 0;
   int          bad = 0;

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .starve_cnt(starve_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [5:0] idx(input logic [31:0] a);
      return {a[31], a[6:2]};
   endfunction

   // Behavioural synchronous-read memory driven purely by the arbiter's memory port.
   always @(posedge clk) begin
      if (mem_we) bram[idx(mem_addr)] <= mem_wdata;
      mem_rdata <= bram[idx(mem_addr)];
   end

   function automatic vec_t mk(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                               input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                               input logic eg0, input logic eg1, input logic [3:0] es);
      vec_t v;
      v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
      v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
      v.eg0 = eg0; v.eg1 = eg1; v.eStarve = es;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Responses owed from last cycle's read grant must appear now, tagged to the right master.
   task automatic checkResponse();
      rsp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checkOutput("m0_rvalid", {31'd0, m0_rvalid}, {31'd0, ~e.who});
         checkOutput("m1_rvalid", {31'd0, m1_rvalid}, {31'd0, e.who});
         checkOutput("m0_rdata", m0_rdata, e.who ? 32'd0 : e.data);
         checkOutput("m1_rdata", m1_rdata, e.who ? e.data : 32'd0);
      end else begin
         checkOutput("m0_rvalid_idle", {31'd0, m0_rvalid}, 32'd0);
         checkOutput("m1_rvalid_idle", {31'd0, m1_rvalid}, 32'd0);
         checkOutput("m0_rdata_idle", m0_rdata, 32'd0);
         checkOutput("m1_rdata_idle", m1_rdata, 32'd0);
      end
   endtask

   // Called at a falling edge: drive one cycle, check it, update the model, move to the next falling edge.
   task automatic applyStimulus(input vec_t v);
      logic [31:0] expAddr, expWdata;
      logic        expWe;
      rsp_t        r;
      m0_req = v.r0; m0_we = v.w0; m0_addr = v.a0; m0_wdata = v.d0;
      m1_req = v.r1; m1_we = v.w1; m1_addr = v.a1; m1_wdata = v.d1;
      #1;
      expWe    = (v.eg0 & v.w0) | (v.eg1 & v.w1);
      expAddr  = v.eg0 ? v.a0 : (v.eg1 ? v.a1 : lastAddr);
      expWdata = v.eg0 ? v.d0 : (v.eg1 ? v.d1 : 32'd0);
      checkOutput("m0_gnt", {31'd0, m0_gnt}, {31'd0, v.eg0});
      checkOutput("m1_gnt", {31'd0, m1_gnt}, {31'd0, v.eg1});
      checkOutput("starve_cnt", {28'd0, starve_cnt}, {28'd0, v.eStarve});
      checkOutput("mem_we", {31'd0, mem_we}, {31'd0, expWe});
      checkOutput("mem_addr", mem_addr, expAddr);
      checkOutput("mem_wdata", mem_wdata, expWdata);
      checkResponse();
      if (v.eg0 || v.eg1) begin
         lastAddr = expAddr;
         if (expWe) begin
            refMem[idx(expAddr)] = expWdata;
         end else begin
            r.who  = v.eg1;
            r.data = refMem[idx(expAddr)];
            sb.push_back(r);
         end
      end
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         bram[i]   = 32'hA500_0000 | i;
         refMem[i] = 32'hA500_0000 | i;
      end
      lastAddr = 32'd0;

      vecs.push_back(mk(1, 1, 32'h40, 32'hDEAD_BEEF, 0, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(1, 0, 32'h40, 0, 0, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int k = 0; k < 10; k++)
         vecs.push_back(mk(1, 0, 32'h10, 0, 1, 0, 32'h20, 0, (k % 5) != 4, (k % 5) == 4, 4'(k % 5)));
      vecs.push_back(mk(1, 0, 32'h10, 0, 0, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 32'h20, 0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'h20, 32'h1234_5678, 0, 1, 0));
      vecs.push_back(mk(1, 0, 32'h20, 0, 0, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(1, 0, 32'h40, 0, 1, 0, 32'h10, 0, 1, 0, 0));
      vecs.push_back(mk(1, 0, 32'h40, 0, 0, 0, 0, 0, 1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'h8000_0008, 32'hCAFE_F00D, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 32'h8000_0004, 0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 32'h8000_0008, 0, 0, 1, 0));

      // Requests held during reset must not produce grants or writes.
      rst_n = 1'b0;
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h40; m0_wdata = 32'h1;
      m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0;  m1_wdata = 32'h0;
      repeat (2) @(negedge clk);
      #1;
      checkOutput("rst_m0_gnt", {31'd0, m0_gnt}, 32'd0);
      checkOutput("rst_m1_gnt", {31'd0, m1_gnt}, 32'd0);
      checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
      checkOutput("rst_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
      checkOutput("rst_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
      checkOutput("rst_starve", {28'd0, starve_cnt}, 32'd0);
      @(negedge clk);

      rst_n = 1'b1;
      applyStimulus(mk(1, 0, 32'h0, 0, 0, 0, 0, 0, 1, 0, 0));

      foreach (vecs[i]) applyStimulus(vecs[i]);

      // Reset lands while the m1 read response is pending: it must be dropped.
      rst_n = 1'b0;
      sb.delete();
      lastAddr = 32'd0;
      m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
      #1;
      checkOutput("midrst_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
      checkOutput("midrst_m1_rdata", m1_rdata, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
